// File: rtl/boot_loader.sv
// Framed byte-stream program loader: parses SYNC/HDR/LEN/DATA/CSUM frames,
// writes payload into program memory and controls the CPU reset line.
module boot_loader #(
    parameter int ADDR_W   = 6,
    parameter int TIMEOUT  = 1024,
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int             MAX_LEN = 1 << ADDR_W;
    localparam int             TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [7:0]     SYNC    = 8'hA5;

    localparam logic [1:0] C_LOAD_RUN = 2'b01;
    localparam logic [1:0] C_RUN      = 2'b10;
    localparam logic [1:0] C_HALT     = 2'b11;

    localparam logic [1:0] E_CSUM = 2'b01;
    localparam logic [1:0] E_TOUT = 2'b10;
    localparam logic [1:0] E_LEN  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_CSUM} state_t;

    state_t            state_q;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [7:0]        sum_q;
    logic [TW-1:0]     to_q;
    logic              rdy_q;
    logic              we_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [7:0]        wdata_q;
    logic              cpu_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        code_q;

    logic       accept;
    logic [7:0] sum_d;
    logic       len_bad;

    assign accept  = rx_valid && rdy_q;
    assign sum_d   = sum_q + rx_data;
    assign len_bad = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            cpu_q   <= ~AUTO_RUN;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            rdy_q  <= 1'b1;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                to_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (rx_data == SYNC) begin
                            err_q   <= 1'b0;
                            code_q  <= '0;
                            state_q <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        cmd_q  <= rx_data[7:6];
                        addr_q <= rx_data[ADDR_W-1:0];
                        sum_q  <= rx_data;
                        case (rx_data[7:6])
                            C_RUN: begin
                                cpu_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                            C_HALT: begin
                                cpu_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                            default: begin
                                // Grab the memory port before any payload arrives.
                                cpu_q   <= 1'b1;
                                state_q <= S_LEN;
                            end
                        endcase
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            err_q   <= 1'b1;
                            code_q  <= E_LEN;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= (ADDR_W+1)'(rx_data);
                            sum_q   <= sum_d;
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        we_q    <= 1'b1;
                        maddr_q <= addr_q;
                        wdata_q <= rx_data;
                        addr_q  <= addr_q + 1'b1;
                        sum_q   <= sum_d;
                        cnt_q   <= cnt_q - 1'b1;
                        if (cnt_q == (ADDR_W+1)'(1))
                            state_q <= S_CSUM;
                    end
                    S_CSUM: begin
                        // Release lands one cycle after the last write strobe at the earliest.
                        if (sum_d == 8'd0) begin
                            done_q <= 1'b1;
                            if (cmd_q == C_LOAD_RUN)
                                cpu_q <= 1'b0;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= E_CSUM;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE) begin
                if (TIMEOUT > 0 && to_q == TO_LAST) begin
                    err_q   <= 1'b1;
                    code_q  <= E_TOUT;
                    to_q    <= '0;
                    state_q <= S_IDLE;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end else begin
                to_q <= '0;
            end
        end
    end

    assign rx_ready  = rdy_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign cpu_reset = cpu_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: frame vectors with a write scoreboard fed by a
// small offline frame parser, plus hand sequences for timeout/reset/max length.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];
    logic [13:0] e_w;

    typedef struct {
        int          n;
        logic [63:0] b;
        logic        d;
        logic        e;
        logic [1:0]  c;
        logic        cpu;
    } vec_t;

    vec_t vt[8];

    boot_loader #(.ADDR_W(6), .TIMEOUT(16), .AUTO_RUN(1'b0)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard side: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                chk("we_with_cpu_held", cpu_reset, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h expected=none", mem_addr, mem_wdata);
                end else begin
                    e_w = exp_q.pop_front();
                    chk("write", {mem_addr, mem_wdata}, e_w);
                end
            end
            if (done)
                chk("done_err_exclusive", err, 0);
        end
    end

    function automatic void model(input logic [7:0] q[$]);
        int i;
        int len;
        logic [7:0] h;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 2 < q.size()) begin
            h   = q[i+1];
            len = int'(q[i+2]);
            if (h[7] == 1'b0 && len >= 1 && len <= 64)
                for (int k = 0; k < len && i + 3 + k < q.size(); k++)
                    exp_q.push_back({6'(int'(h[5:0]) + k), q[i+3+k]});
        end
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] q[$]);
        model(q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic apply_vec(input int v);
        logic [7:0] q[$];
        for (int j = 0; j < vt[v].n; j++) q.push_back(vt[v].b[63-8*j -: 8]);
        run_frame(q);
        chk($sformatf("v%0d_done", v), done, vt[v].d);
        chk($sformatf("v%0d_err", v), err, vt[v].e);
        chk($sformatf("v%0d_code", v), err_code, vt[v].c);
        chk($sformatf("v%0d_cpu", v), cpu_reset, vt[v].cpu);
        chk($sformatf("v%0d_idle", v), busy, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulse", v), done, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_writes_drained", v), exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;

        vt[0] = '{6, 64'hA5_50_02_11_22_7B_00_00, 1'b1, 1'b0, 2'b00, 1'b0};
        vt[1] = '{6, 64'hA5_3F_02_AA_BB_5A_00_00, 1'b1, 1'b0, 2'b00, 1'b1};
        vt[2] = '{6, 64'hA5_50_02_11_22_00_00_00, 1'b0, 1'b1, 2'b01, 1'b1};
        vt[3] = '{3, 64'hA5_00_00_00_00_00_00_00, 1'b0, 1'b1, 2'b11, 1'b1};
        vt[4] = '{3, 64'hA5_00_41_00_00_00_00_00, 1'b0, 1'b1, 2'b11, 1'b1};
        vt[5] = '{2, 64'hA5_80_00_00_00_00_00_00, 1'b1, 1'b0, 2'b00, 1'b0};
        vt[6] = '{2, 64'hA5_C0_00_00_00_00_00_00, 1'b1, 1'b0, 2'b00, 1'b1};
        vt[7] = '{4, 64'h12_34_A5_80_00_00_00_00, 1'b1, 1'b0, 2'b00, 1'b0};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_ready", rx_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_ready_after_rst", rx_ready, 1);

        for (int v = 0; v < 3; v++) apply_vec(v);

        // Sticky error survives idle cycles and clears on the next SYNC.
        repeat (4) @(posedge clk);
        #1;
        chk("err_sticky", err, 1);
        send(8'hA5);
        chk("sync_clears_err", err, 0);
        chk("sync_clears_code", err_code, 0);
        chk("sync_busy", busy, 1);
        send(8'hC0);
        chk("halt_done", done, 1);
        chk("halt_cpu", cpu_reset, 1);

        for (int v = 3; v < 5; v++) apply_vec(v);

        // Timeout: 15 empty cycles keep the frame alive, the 16th aborts it.
        q = {8'hA5, 8'h00};
        run_frame(q);
        repeat (15) @(posedge clk);
        #1;
        chk("to_still_busy", busy, 1);
        chk("to_no_err_yet", err, 0);
        @(posedge clk);
        #1;
        chk("to_err", err, 1);
        chk("to_code", err_code, 2'b10);
        chk("to_busy", busy, 0);
        chk("to_cpu", cpu_reset, 1);

        for (int v = 5; v < 8; v++) apply_vec(v);

        // Maximum length 64 LOAD_RUN frame from address 0.
        q = {8'hA5, 8'h40, 8'h40};
        s = 8'h40 + 8'h40;
        for (int i = 0; i < 64; i++) begin
            q.push_back(8'(i * 3 + 1));
            s = s + 8'(i * 3 + 1);
        end
        q.push_back(8'(0) - s);
        run_frame(q);
        chk("len64_done", done, 1);
        chk("len64_cpu", cpu_reset, 0);
        chk("len64_err", err, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("len64_drained", exp_q.size(), 0);

        // Reset mid-DATA kills the pending write and the frame.
        exp_q.push_back({6'h00, 8'h11});
        send(8'hA5);
        send(8'h00);
        send(8'h04);
        send(8'h11);
        send(8'h22);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cpu", cpu_reset, 1);
        chk("mid_rst_ready", rx_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ready", rx_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
